regfile_sb: RTL and testbench

- Parametrised successor to the 4x10 processor register file: DEPTH registers of WIDTH bits.
- One synchronous write port and two combinational, tri-stated read ports.
- Adds a per-register pending scoreboard so the control unit can stall on read-after-write hazards from multi-cycle producers.
- Adds synchronous clearing of all registers on reset.
- Sits between the datapath bus and the control FSM.

---
 rtl/regfile_sb_pkg.sv | 16 +
 rtl/regfile_sb_if.sv | 44 ++++
 rtl/regfile_sb_scoreboard.sv | 39 +++
 rtl/regfile_sb.sv | 84 ++++++++
 tb/tb_regfile_sb.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_sb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the regfile_sb register file slice.
//   REGFILE_WIDTH : default data width of each register
//   REGFILE_DEPTH : default number of registers (power of two, >= 2)
//   reg_addr_t    : register address type for the default depth
// Optional build macro used by this slice: REGFILE_SB_BYPASS_EN
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REGFILE_WIDTH = 10;
    localparam int REGFILE_DEPTH = 4;

    typedef logic [$clog2(REGFILE_DEPTH)-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_sb_if.sv
// ----------------------------------------------------------------------------
// regfile_sb_if
// Bus between the datapath/control unit and the register file.
//   D, WRA, ENW          : write port (data, address, enable)
//   ISS, ISA             : issue strobe and destination of an in-flight producer
//   RDA0/ENR0, RDA1/ENR1 : read address and enable, ports 0 and 1
//   RDY0, RDY1           : operand-valid flags returned by the register file
//   BUSY                 : registered pending vector, one bit per register
// The tri-stated read data Q0/Q1 are plain ports of regfile_sb.
// modport master : control side (drives addresses/strobes)
// modport slave  : register file side
// ----------------------------------------------------------------------------
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = REGFILE_WIDTH,
    parameter int DEPTH = REGFILE_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  D;
    logic [ADDR_W-1:0] WRA;
    logic              ENW;
    logic              ISS;
    logic [ADDR_W-1:0] ISA;
    logic [ADDR_W-1:0] RDA0;
    logic              ENR0;
    logic [ADDR_W-1:0] RDA1;
    logic              ENR1;
    logic              RDY0;
    logic              RDY1;
    logic [DEPTH-1:0]  BUSY;

    modport master (
        output D, WRA, ENW, ISS, ISA, RDA0, ENR0, RDA1, ENR1,
        input  RDY0, RDY1, BUSY
    );

    modport slave (
        input  D, WRA, ENW, ISS, ISA, RDA0, ENR0, RDA1, ENR1,
        output RDY0, RDY1, BUSY
    );

endinterface : regfile_sb_if

// File: rtl/regfile_sb_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
// Per-register pending bits for read-after-write hazard detection.
//   clk, rst           : clock and synchronous active-high reset
//   clr_en, clr_addr   : a completed write clears the pending bit
//   set_en, set_addr   : an issued producer sets the pending bit
//   busy               : registered pending vector
// A set and a clear of the same bit on one edge leave the bit set, because
// the set represents a newer producer than the write that just completed.
// ----------------------------------------------------------------------------
module rf_scoreboard #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_en,
    input  logic [$clog2(DEPTH)-1:0] clr_addr,
    input  logic                     set_en,
    input  logic [$clog2(DEPTH)-1:0] set_addr,
    output logic [DEPTH-1:0]         busy
);
    logic [DEPTH-1:0] pending;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            // NOTE: the set is written after the clear on purpose; the last
            // non-blocking assignment to a bit wins, giving set priority.
            if (clr_en) pending[clr_addr] <= 1'b0;
            if (set_en) pending[set_addr] <= 1'b1;
        end
    end

    assign busy = pending;

endmodule : rf_scoreboard

// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
// DEPTH x WIDTH register file with one synchronous write port, two
// combinational tri-stated read ports and a pending scoreboard.
//   Clkb : clock, all state changes on the rising edge
//   Rst  : synchronous active-high reset; clears data and pending bits
//   bus  : regfile_sb_if.slave (write, issue, read addresses, RDY, BUSY)
//   Q0   : read data port 0, high-Z when ENR0 is low
//   Q1   : read data port 1, high-Z when ENR1 is low
// Build macro REGFILE_SB_BYPASS_EN: forward write data (and its ready status)
// to a read port addressing the register being written in the same cycle.
// ----------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = REGFILE_WIDTH,
    parameter int DEPTH = REGFILE_DEPTH
) (
    input  logic             Clkb,
    input  logic             Rst,
    regfile_sb_if.slave      bus,
    output wire [WIDTH-1:0]  Q0,
    output wire [WIDTH-1:0]  Q1
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [WIDTH-1:0] rd_data0;
    logic [WIDTH-1:0] rd_data1;
    logic             rd_valid0;
    logic             rd_valid1;

    // NOTE: the array is cleared on reset because a flushed machine must read
    // zeros; this forces flops rather than a RAM macro, which is fine at this size.
    always_ff @(posedge Clkb) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (bus.ENW) begin
            regs[bus.WRA] <= bus.D;
        end
    end

    rf_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
        .clk      (Clkb),
        .rst      (Rst),
        .clr_en   (bus.ENW),
        .clr_addr (bus.WRA),
        .set_en   (bus.ISS),
        .set_addr (bus.ISA),
        .busy     (pending)
    );

`ifdef REGFILE_SB_BYPASS_EN
    logic fwd0;
    logic fwd1;
    logic fwd_pending;

    // A forwarded operand is only ready if no newer producer is issued to the
    // same destination in this cycle.
    assign fwd_pending = bus.ISS && (bus.ISA == bus.WRA);
    assign fwd0        = bus.ENW && (bus.RDA0 == bus.WRA);
    assign fwd1        = bus.ENW && (bus.RDA1 == bus.WRA);

    assign rd_data0  = fwd0 ? bus.D : regs[bus.RDA0];
    assign rd_data1  = fwd1 ? bus.D : regs[bus.RDA1];
    assign rd_valid0 = fwd0 ? ~fwd_pending : ~pending[bus.RDA0];
    assign rd_valid1 = fwd1 ? ~fwd_pending : ~pending[bus.RDA1];
`else
    // Reads see pre-edge state: a same-cycle write shows up next cycle.
    assign rd_data0  = regs[bus.RDA0];
    assign rd_data1  = regs[bus.RDA1];
    assign rd_valid0 = ~pending[bus.RDA0];
    assign rd_valid1 = ~pending[bus.RDA1];
`endif

    assign Q0 = bus.ENR0 ? rd_data0 : {WIDTH{1'bz}};
    assign Q1 = bus.ENR1 ? rd_data1 : {WIDTH{1'bz}};

    assign bus.RDY0 = bus.ENR0 & rd_valid0;
    assign bus.RDY1 = bus.ENR1 & rd_valid1;
    assign bus.BUSY = pending;

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_sb
// Directed self-checking bench for regfile_sb (default 4 x 10 configuration).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled before the next rising edge.
// ----------------------------------------------------------------------------
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int W = REGFILE_WIDTH;
    localparam int N = REGFILE_DEPTH;

    logic         Clkb;
    logic         Rst;
    wire  [W-1:0] Q0;
    wire  [W-1:0] Q1;
    logic [W-1:0] zval;

    int checks;
    int errors;

    regfile_sb_if #(.WIDTH(W), .DEPTH(N)) bus ();

    regfile_sb #(.WIDTH(W), .DEPTH(N)) dut (
        .Clkb (Clkb),
        .Rst  (Rst),
        .bus  (bus),
        .Q0   (Q0),
        .Q1   (Q1)
    );

    initial Clkb = 1'b0;
    always #5 Clkb = ~Clkb;

    task automatic tick();
        @(posedge Clkb);
        #1;
    endtask

    task automatic idle();
        bus.ENW = 1'b0;
        bus.ISS = 1'b0;
        bus.D   = '0;
        bus.WRA = '0;
        bus.ISA = '0;
    endtask

    task automatic write_reg(input reg_addr_t a, input logic [W-1:0] d);
        bus.ENW = 1'b1; bus.WRA = a; bus.D = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        bus.ENR0 = 1'b1; bus.ENR1 = 1'b1;
        for (int a = 0; a < N; a++) begin
            bus.RDA0 = reg_addr_t'(a);
            bus.RDA1 = reg_addr_t'(a);
            #1;
            checks += 4;
            if (Q0 !== 10'h000) begin errors++; $display("FAIL reset_q0 addr %0d got %h want 000", a, Q0); end
            if (Q1 !== 10'h000) begin errors++; $display("FAIL reset_q1 addr %0d got %h want 000", a, Q1); end
            if (bus.RDY0 !== 1'b1) begin errors++; $display("FAIL reset_rdy0 addr %0d got %b want 1", a, bus.RDY0); end
            if (bus.RDY1 !== 1'b1) begin errors++; $display("FAIL reset_rdy1 addr %0d got %b want 1", a, bus.RDY1); end
        end
        checks++;
        if (bus.BUSY !== 4'b0000) begin errors++; $display("FAIL reset_busy got %b want 0000", bus.BUSY); end
    endtask

    task automatic test_write_read();
        write_reg(2'd2, 10'h3A5);
        write_reg(2'd1, 10'h0FF);
        bus.ENR0 = 1'b1; bus.RDA0 = 2'd2;
        bus.ENR1 = 1'b1; bus.RDA1 = 2'd1;
        #1;
        checks += 2;
        if (Q0 !== 10'h3A5) begin errors++; $display("FAIL wr_q0 got %h want 3a5", Q0); end
        if (Q1 !== 10'h0FF) begin errors++; $display("FAIL wr_q1 got %h want 0ff", Q1); end
        // Tri-state on a disabled port.
        bus.ENR1 = 1'b0;
        #1;
        checks += 3;
        if (Q1 !== zval) begin errors++; $display("FAIL tristate_q1 got %h want z", Q1); end
        if (bus.RDY1 !== 1'b0) begin errors++; $display("FAIL tristate_rdy1 got %b want 0", bus.RDY1); end
        if (Q0 !== 10'h3A5) begin errors++; $display("FAIL tristate_q0_kept got %h want 3a5", Q0); end
    endtask

    task automatic test_dual_read();
        bus.ENR0 = 1'b1; bus.RDA0 = 2'd2;
        bus.ENR1 = 1'b1; bus.RDA1 = 2'd2;
        #1;
        checks += 2;
        if (Q0 !== 10'h3A5) begin errors++; $display("FAIL dual_q0 got %h want 3a5", Q0); end
        if (Q1 !== 10'h3A5) begin errors++; $display("FAIL dual_q1 got %h want 3a5", Q1); end
    endtask

    task automatic test_scoreboard();
        bus.ISS = 1'b1; bus.ISA = 2'd3;
        tick();
        idle();
        bus.ENR0 = 1'b1; bus.RDA0 = 2'd3;
        #1;
        checks += 2;
        if (bus.BUSY !== 4'b1000) begin errors++; $display("FAIL sb_busy_set got %b want 1000", bus.BUSY); end
        if (bus.RDY0 !== 1'b0) begin errors++; $display("FAIL sb_rdy0_pending got %b want 0", bus.RDY0); end
        // During the completing write the port still sees the old status.
        bus.ENW = 1'b1; bus.WRA = 2'd3; bus.D = 10'h155;
        #1;
        checks++;
`ifdef REGFILE_SB_BYPASS_EN
        if (bus.RDY0 !== 1'b1) begin errors++; $display("FAIL sb_rdy0_fwd got %b want 1", bus.RDY0); end
`else
        if (bus.RDY0 !== 1'b0) begin errors++; $display("FAIL sb_rdy0_same_cycle got %b want 0", bus.RDY0); end
`endif
        tick();
        idle();
        #1;
        checks += 3;
        if (bus.BUSY !== 4'b0000) begin errors++; $display("FAIL sb_busy_clr got %b want 0000", bus.BUSY); end
        if (bus.RDY0 !== 1'b1) begin errors++; $display("FAIL sb_rdy0_clr got %b want 1", bus.RDY0); end
        if (Q0 !== 10'h155) begin errors++; $display("FAIL sb_q0 got %h want 155", Q0); end
    endtask

    task automatic test_set_clear();
        bus.ISS = 1'b1; bus.ISA = 2'd1;
        tick();
        // Same address: write and re-issue on one edge.
        bus.ENW = 1'b1; bus.WRA = 2'd1; bus.D = 10'h123;
        bus.ISS = 1'b1; bus.ISA = 2'd1;
`ifdef REGFILE_SB_BYPASS_EN
        bus.ENR0 = 1'b1; bus.RDA0 = 2'd1;
        #1;
        checks += 2;
        if (Q0 !== 10'h123) begin errors++; $display("FAIL sc_fwd_q0 got %h want 123", Q0); end
        if (bus.RDY0 !== 1'b0) begin errors++; $display("FAIL sc_fwd_rdy0 got %b want 0", bus.RDY0); end
`endif
        tick();
        idle();
        bus.ENR0 = 1'b1; bus.RDA0 = 2'd1;
        #1;
        checks += 3;
        if (bus.BUSY !== 4'b0010) begin errors++; $display("FAIL sc_busy_same got %b want 0010", bus.BUSY); end
        if (Q0 !== 10'h123) begin errors++; $display("FAIL sc_q0_same got %h want 123", Q0); end
        if (bus.RDY0 !== 1'b0) begin errors++; $display("FAIL sc_rdy0_same got %b want 0", bus.RDY0); end
        // Different addresses: clear r1 and set r0 together.
        bus.ENW = 1'b1; bus.WRA = 2'd1; bus.D = 10'h0AB;
        bus.ISS = 1'b1; bus.ISA = 2'd0;
        tick();
        idle();
        #1;
        checks += 2;
        if (bus.BUSY !== 4'b0001) begin errors++; $display("FAIL sc_busy_diff got %b want 0001", bus.BUSY); end
        if (Q0 !== 10'h0AB) begin errors++; $display("FAIL sc_q0_diff got %h want 0ab", Q0); end
    endtask

    task automatic test_read_during_write();
        write_reg(2'd0, 10'h001);
        bus.ENR0 = 1'b1; bus.RDA0 = 2'd0;
        bus.ENW = 1'b1; bus.WRA = 2'd0; bus.D = 10'h2AA;
        #1;
        checks++;
`ifdef REGFILE_SB_BYPASS_EN
        if (Q0 !== 10'h2AA) begin errors++; $display("FAIL rdw_q0_now got %h want 2aa", Q0); end
`else
        if (Q0 !== 10'h001) begin errors++; $display("FAIL rdw_q0_now got %h want 001", Q0); end
`endif
        tick();
        idle();
        #1;
        checks += 2;
        if (Q0 !== 10'h2AA) begin errors++; $display("FAIL rdw_q0_next got %h want 2aa", Q0); end
        if (bus.BUSY !== 4'b0000) begin errors++; $display("FAIL rdw_busy got %b want 0000", bus.BUSY); end
    endtask

    task automatic test_reset_priority();
        bus.ISS = 1'b1; bus.ISA = 2'd2;
        tick();
        Rst = 1'b1;
        bus.ENW = 1'b1; bus.WRA = 2'd0; bus.D = 10'h3FF;
        bus.ISS = 1'b1; bus.ISA = 2'd0;
        tick();
        Rst = 1'b0;
        idle();
        bus.ENR0 = 1'b1; bus.RDA0 = 2'd0;
        bus.ENR1 = 1'b1; bus.RDA1 = 2'd2;
        #1;
        checks += 4;
        if (Q0 !== 10'h000) begin errors++; $display("FAIL rstp_q0 got %h want 000", Q0); end
        if (Q1 !== 10'h000) begin errors++; $display("FAIL rstp_q1 got %h want 000", Q1); end
        if (bus.BUSY !== 4'b0000) begin errors++; $display("FAIL rstp_busy got %b want 0000", bus.BUSY); end
        if (bus.RDY1 !== 1'b1) begin errors++; $display("FAIL rstp_rdy1 got %b want 1", bus.RDY1); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        zval   = {W{1'bz}};
        Rst    = 1'b1;
        idle();
        bus.RDA0 = '0; bus.ENR0 = 1'b0;
        bus.RDA1 = '0; bus.ENR1 = 1'b0;
        #2;
        test_reset();
        test_write_read();
        test_dual_read();
        test_scoreboard();
        test_set_clear();
        test_read_during_write();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_sb
